bcd_display_driver: RTL and testbench

- Downstream output stage of the multiplier datapath.
- Captures the 8-bit result held in datapath register 0 when the control state machine strobes it.
- Converts the result to BCD sequentially, using shift-add-3 with one bit per clock.
- Time-multiplexes the BCD digits onto a 4-digit common-anode 7-segment display.

---
 rtl/display_pkg.sv | 34 +++
 rtl/seg7_encoder.sv | 26 ++
 rtl/bcd_display_driver.sv | 118 +++++++++++
 tb/tb_bcd_display_driver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared FSM encodings, segment constants and the BCD add-3 helper for the display driver.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;

  // Segment order {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  function automatic logic [15:0] bcd_add3(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Nibble to active-low 7-segment pattern; anything above 9 is blanked.
module seg7_encoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Captures a binary result, converts it to BCD one bit per clock and scans it onto a 4-digit display.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int clk_freq   = 50000000,
  parameter int DATAWIDTH  = 8,
  parameter int REFRESH_HZ = 1000
) (
  input  logic                 clk,
  input  logic                 lowRst,
  input  logic [DATAWIDTH-1:0] sDataIn,
  input  logic                 sLoad,
  output logic                 sBusy,
  output logic                 sDone,
  output logic [6:0]           sSeg,
  output logic [3:0]           sAnode
);

  localparam int DIVIDE = clk_freq / (REFRESH_HZ * 4);
  localparam int PW     = $clog2(DIVIDE);
  localparam int CW     = $clog2(DATAWIDTH + 1);

  state_t                 state;
  logic [DATAWIDTH-1:0]   shift_q;
  logic [15:0]            scratch_q;
  logic [15:0]            disp_q;
  logic [CW-1:0]          iter_q;
  logic [PW-1:0]          presc_q;
  logic [1:0]             idx_q;
  logic [16+DATAWIDTH-1:0] shifted;
  logic [3:0]             cur_nibble;
  logic [6:0]             enc_seg;
  logic [6:0]             seg_next;
  logic                   upper_zero;

  assign shifted = {bcd_add3(scratch_q), shift_q} << 1;

  always_ff @(posedge clk or negedge lowRst) begin
    if (!lowRst) begin
      state     <= IDLE;
      sBusy     <= 1'b0;
      sDone     <= 1'b0;
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      disp_q    <= '0;
    end else begin
      sDone <= 1'b0;
      case (state)
        IDLE: begin
          if (sLoad) begin
            shift_q   <= sDataIn;
            scratch_q <= '0;
            iter_q    <= '0;
            sBusy     <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= shifted[16+DATAWIDTH-1:DATAWIDTH];
          shift_q   <= shifted[DATAWIDTH-1:0];
          iter_q    <= iter_q + CW'(1);
          if (iter_q == CW'(DATAWIDTH - 1)) state <= DONE;
        end
        DONE: begin
          disp_q <= scratch_q;
          sDone  <= 1'b1;
          sBusy  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cur_nibble = disp_q[{idx_q, 2'b00} +: 4];

  seg7_encoder u_seg7_encoder (
    .nibble (cur_nibble),
    .seg    (enc_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more significant digit are zero; digit 0 always shows.
  always_comb begin
    upper_zero = 1'b0;
    case (idx_q)
      2'd1:    upper_zero = (disp_q[15:4] == 12'd0);
      2'd2:    upper_zero = (disp_q[15:8] == 8'd0);
      2'd3:    upper_zero = (disp_q[15:12] == 4'd0);
      default: upper_zero = 1'b0;
    endcase
  end
`else
  assign upper_zero = 1'b0;
`endif

  assign seg_next = upper_zero ? SEG_BLANK : enc_seg;

  // Outputs reflect the digit selected before the index advances, so digit 0 lights first.
  always_ff @(posedge clk or negedge lowRst) begin
    if (!lowRst) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      sSeg    <= SEG_BLANK;
      sAnode  <= 4'b1111;
    end else if (presc_q == PW'(DIVIDE - 1)) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
      sAnode  <= ~(4'b0001 << idx_q);
      sSeg    <= seg_next;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver with a 4-clock scan period; follows LEADING_ZERO_BLANK_EN.
module tb_bcd_display_driver;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          lowRst = 1'b0;
  logic          sLoad = 1'b0;
  logic [DW-1:0] sDataIn = '0;
  logic          sBusy;
  logic          sDone;
  logic [6:0]    sSeg;
  logic [3:0]    sAnode;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] cap [4];
  logic [3:0] an_hist [32];

  always #5 clk = ~clk;

  bcd_display_driver #(
    .clk_freq   (400),
    .DATAWIDTH  (DW),
    .REFRESH_HZ (25)
  ) dut (
    .clk     (clk),
    .lowRst  (lowRst),
    .sDataIn (sDataIn),
    .sLoad   (sLoad),
    .sBusy   (sBusy),
    .sDone   (sDone),
    .sSeg    (sSeg),
    .sAnode  (sAnode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && v < p) return 7'b1111111;
`endif
    return seg_code((v / p) % 10);
  endfunction

  task automatic capture_scan();
    for (int d = 0; d < 4; d++) cap[d] = 7'h2A;
    repeat (8) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      case (sAnode)
        4'b1110: cap[0] = sSeg;
        4'b1101: cap[1] = sSeg;
        4'b1011: cap[2] = sSeg;
        4'b0111: cap[3] = sSeg;
        default: ;
      endcase
    end
  endtask

  task automatic check_display(input int v, input string tag);
    capture_scan();
    for (int d = 0; d < 4; d++)
      check($sformatf("%s_digit%0d", tag, d), {25'd0, cap[d]}, {25'd0, exp_seg(v, d)});
  endtask

  // Leaves the bench #1 after edge k, the edge that samples sLoad.
  task automatic pulse_load(input int v);
    @(negedge clk);
    sDataIn = DW'(v);
    sLoad   = 1'b1;
    @(posedge clk); #1;
    sLoad   = 1'b0;
  endtask

  task automatic convert(input int v);
    int lat;
    int busy_cnt;
    string tag;
    tag = $sformatf("val%0d", v);
    pulse_load(v);
    check({tag, "_busy_start"}, {31'd0, sBusy}, 32'd1);
    busy_cnt = 1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sDone) begin
        lat = i;
        break;
      end
      if (sBusy) busy_cnt++;
    end
    check({tag, "_done_latency"}, lat, DW + 1);
    check({tag, "_busy_cycles"}, busy_cnt, DW + 1);
    check({tag, "_busy_at_done"}, {31'd0, sBusy}, 32'd0);
    check_display(v, tag);
  endtask

  initial begin
    int n_done;
    int first_done;
    int cyc;

    // Reset held with a load request present.
    lowRst  = 1'b0;
    sLoad   = 1'b1;
    sDataIn = 8'd87;
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", {25'd0, sSeg}, 32'h7F);
    check("rst_anode", {28'd0, sAnode}, 32'hF);
    check("rst_busy", {31'd0, sBusy}, 32'd0);
    check("rst_done", {31'd0, sDone}, 32'd0);

    @(negedge clk);
    sLoad  = 1'b0;
    lowRst = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      @(posedge clk); #1;
      an_hist[i] = sAnode;
    end
    for (int i = 1; i <= 3; i++) check($sformatf("scan_pre_wrap_c%0d", i), {28'd0, an_hist[i]}, 32'hF);
    for (int i = 4; i <= 20; i++)
      check($sformatf("scan_anode_c%0d", i), {28'd0, an_hist[i]},
            {28'd0, ~(4'b0001 << (((i - 4) / 4) % 4))});
    check("post_rst_busy", {31'd0, sBusy}, 32'd0);
    check_display(0, "post_rst");

    convert(87);
    convert(255);
    convert(0);
    convert(99);
    convert(100);
    convert(7);

    // Second load while busy must be ignored.
    pulse_load(200);
    cyc = 0;
    n_done = 0;
    first_done = 0;
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    @(negedge clk);
    sDataIn = 8'd13;
    sLoad   = 1'b1;
    @(posedge clk); cyc++;
    #1;
    sLoad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); cyc++;
      #1;
      if (sDone) begin
        n_done++;
        if (first_done == 0) first_done = cyc;
      end
    end
    check("reject_done_count", n_done, 1);
    check("reject_done_cycle", first_done, DW + 1);
    check_display(200, "reject");

    // Reset in the middle of a conversion.
    pulse_load(50);
    repeat (4) @(posedge clk);
    #1;
    lowRst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, sBusy}, 32'd0);
    check("midrst_done", {31'd0, sDone}, 32'd0);
    check("midrst_seg", {25'd0, sSeg}, 32'h7F);
    check("midrst_anode", {28'd0, sAnode}, 32'hF);
    @(negedge clk);
    lowRst = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sDone) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    check_display(0, "midrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
